// File: rtl/prom_loader_pkg.sv
// Shared definitions for the program ROM loader: state encoding and instruction format.
package prom_loader_pkg;

  localparam int unsigned INSTR_W       = 15;
  localparam int unsigned HI_MARKER_BIT = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_WRITE = 3'd3,
    S_CHK   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

endpackage

// File: rtl/prom_loader.sv
// Byte-stream instruction image loader: assembles 15-bit words, writes them to
// instruction memory, verifies a trailing 8-bit checksum and gates the CPU.
module prom_loader
  import prom_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned WORDS  = 16
) (
  input  logic               CLK_LD,
  input  logic               RESET,
  input  logic               START,
  input  logic [7:0]         RX_DATA,
  input  logic               RX_VALID,
  output logic               RX_READY,
  output logic               WR_EN,
  output logic [ADDR_W-1:0]  WR_ADDR,
  output logic [INSTR_W-1:0] WR_DATA,
  output logic               CPU_HOLD,
  output logic               LOAD_DONE,
  output logic               LOAD_ERR
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS - 1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [7:0]        acc_q;
  logic              accept;
  logic              begin_load;

  assign accept     = RX_VALID && RX_READY;
  assign begin_load = START && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

  // State register
  always_ff @(posedge CLK_LD) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (START) state_d = S_HI;
      end
      S_HI: begin
        if (accept) state_d = RX_DATA[HI_MARKER_BIT] ? S_ERR : S_LO;
      end
      S_LO: begin
        if (accept) state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = (cnt_q == LAST_IDX) ? S_CHK : S_HI;
      end
      S_CHK: begin
        if (accept) state_d = (RX_DATA == acc_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge CLK_LD) begin
    if (RESET) begin
      RX_READY  <= 1'b0;
      WR_EN     <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= '0;
      CPU_HOLD  <= 1'b0;
      LOAD_DONE <= 1'b0;
      LOAD_ERR  <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
    end else begin
      RX_READY  <= (state_d == S_HI) || (state_d == S_LO) || (state_d == S_CHK);
      WR_EN     <= (state_d == S_WRITE);
      CPU_HOLD  <= !((state_d == S_IDLE) || (state_d == S_DONE));
      LOAD_DONE <= (state_d == S_DONE);
      LOAD_ERR  <= (state_d == S_ERR);

      if (begin_load) begin
        cnt_q <= '0;
        acc_q <= '0;
      end else begin
        if (state_q == S_WRITE && cnt_q != LAST_IDX) cnt_q <= cnt_q + ADDR_W'(1);
        if (accept && (state_q == S_HI || state_q == S_LO)) acc_q <= acc_q + RX_DATA;
      end

      if (accept && state_q == S_HI) WR_DATA[INSTR_W-1:8] <= RX_DATA[HI_MARKER_BIT-1:0];
      if (accept && state_q == S_LO) WR_DATA[7:0] <= RX_DATA;

      // Counter still holds the current word index while LO is being accepted.
      if (state_d == S_WRITE) WR_ADDR <= cnt_q;
    end
  end

endmodule

// File: tb/tb_prom_loader.sv
// Randomized self-checking bench for prom_loader against an image-level reference model.
module tb_prom_loader;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned WORDS  = 16;

  logic              CLK_LD = 1'b0;
  logic              RESET;
  logic              START;
  logic [7:0]        RX_DATA;
  logic              RX_VALID;
  logic              RX_READY;
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [14:0]       WR_DATA;
  logic              CPU_HOLD;
  logic              LOAD_DONE;
  logic              LOAD_ERR;

  prom_loader #(.ADDR_W(ADDR_W), .WORDS(WORDS)) dut (
    .CLK_LD   (CLK_LD),
    .RESET    (RESET),
    .START    (START),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .RX_READY (RX_READY),
    .WR_EN    (WR_EN),
    .WR_ADDR  (WR_ADDR),
    .WR_DATA  (WR_DATA),
    .CPU_HOLD (CPU_HOLD),
    .LOAD_DONE(LOAD_DONE),
    .LOAD_ERR (LOAD_ERR)
  );

  always #5 CLK_LD = ~CLK_LD;

  int errors = 0;
  int checks = 0;

  logic [14:0]       img [WORDS];
  logic [ADDR_W-1:0] wa_q [$];
  logic [14:0]       wd_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture every memory write strobe
  always @(negedge CLK_LD) begin
    if (WR_EN === 1'b1) begin
      wa_q.push_back(WR_ADDR);
      wd_q.push_back(WR_DATA);
    end
  end

  function automatic logic [7:0] img_sum();
    logic [7:0] s = 8'h00;
    for (int i = 0; i < WORDS; i++) s = s + {1'b0, img[i][14:8]} + img[i][7:0];
    return s;
  endfunction

  task automatic pulse_start();
    @(negedge CLK_LD);
    START = 1'b1;
    @(negedge CLK_LD);
    START = 1'b0;
  endtask

  // Offer one byte until it is accepted; optional random stalls and stray START pulses.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit ok = 1'b0;
    for (int guard = 0; guard < 400; guard++) begin
      @(negedge CLK_LD);
      if (stall && $urandom_range(2) == 0) begin
        RX_VALID = 1'b0;
        RX_DATA  = 8'($urandom);
        START    = ($urandom_range(3) == 0);
      end else begin
        START    = 1'b0;
        RX_VALID = 1'b1;
        RX_DATA  = b;
        if (RX_READY) begin
          @(posedge CLK_LD);
          #1;
          RX_VALID = 1'b0;
          ok = 1'b1;
          break;
        end
      end
    end
    START = 1'b0;
    if (!ok) check("rx_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_load(input logic [7:0] chk_byte, input bit stall, input int bad_at);
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    for (int i = 0; i < WORDS; i++) begin
      if (i == bad_at) begin
        send_byte(8'h80 | {1'b0, img[i][14:8]}, stall);
        return;
      end
      send_byte({1'b0, img[i][14:8]}, stall);
      send_byte(img[i][7:0], stall);
      if (!stall) begin
        check("wr_en_latency", 32'(WR_EN), 32'd1);
        check("wr_addr_now", 32'(WR_ADDR), 32'(i));
        check("wr_data_now", 32'(WR_DATA), 32'(img[i]));
      end
    end
    send_byte(chk_byte, stall);
  endtask

  task automatic verify_load(input logic [7:0] chk_byte, input int bad_at);
    int  exp_n;
    bit  exp_done;
    repeat (5) @(negedge CLK_LD);
    exp_n    = (bad_at < 0) ? WORDS : bad_at;
    exp_done = (bad_at < 0) && (chk_byte == img_sum());
    check("write_count", 32'(wa_q.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < wa_q.size(); i++) begin
      check("write_addr", 32'(wa_q[i]), 32'(i));
      check("write_data", 32'(wd_q[i]), 32'(img[i]));
    end
    check("load_done", 32'(LOAD_DONE), 32'(exp_done));
    check("load_err", 32'(LOAD_ERR), 32'(!exp_done));
    check("cpu_hold", 32'(CPU_HOLD), 32'(!exp_done));
    check("rx_ready_idle", 32'(RX_READY), 32'd0);
    check("wr_en_idle", 32'(WR_EN), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_rx_ready", 32'(RX_READY), 32'd0);
    check("rst_wr_en", 32'(WR_EN), 32'd0);
    check("rst_wr_addr", 32'(WR_ADDR), 32'd0);
    check("rst_wr_data", 32'(WR_DATA), 32'd0);
    check("rst_cpu_hold", 32'(CPU_HOLD), 32'd0);
    check("rst_load_done", 32'(LOAD_DONE), 32'd0);
    check("rst_load_err", 32'(LOAD_ERR), 32'd0);
  endtask

  initial begin
    logic [7:0] c;
    RESET    = 1'b1;
    START    = 1'b0;
    RX_VALID = 1'b0;
    RX_DATA  = 8'h00;
    repeat (3) @(negedge CLK_LD);
    check_reset_outputs();
    RESET = 1'b0;
    @(negedge CLK_LD);
    check("idle_rx_ready", 32'(RX_READY), 32'd0);

    // Full good load: every word 0x0001, checksum 0x10
    for (int i = 0; i < WORDS; i++) img[i] = 15'h0001;
    run_load(8'h10, 1'b0, -1);
    verify_load(8'h10, -1);

    // Real program word at address 0, rest random
    img[0] = 15'h4800;
    for (int i = 1; i < WORDS; i++) img[i] = 15'($urandom);
    c = img_sum();
    run_load(c, 1'b0, -1);
    verify_load(c, -1);

    // Framing error at word 3
    for (int i = 0; i < WORDS; i++) img[i] = 15'($urandom);
    run_load(8'h00, 1'b0, 3);
    verify_load(8'h00, 3);

    // Checksum error on the all-ones image
    for (int i = 0; i < WORDS; i++) img[i] = 15'h0001;
    run_load(8'h11, 1'b0, -1);
    verify_load(8'h11, -1);

    // Random images with backpressure and stray START pulses
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < WORDS; i++) img[i] = 15'($urandom);
      c = img_sum() + ((r == 2) ? 8'd1 : 8'd0);
      run_load(c, 1'b1, -1);
      verify_load(c, -1);
    end

    // Reset during LO of word 5, then full reload
    for (int i = 0; i < WORDS; i++) img[i] = 15'($urandom);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      send_byte({1'b0, img[i][14:8]}, 1'b0);
      send_byte(img[i][7:0], 1'b0);
    end
    send_byte({1'b0, img[5][14:8]}, 1'b0);
    @(negedge CLK_LD);
    RX_VALID = 1'b1;
    RX_DATA  = img[5][7:0];
    RESET    = 1'b1;
    @(posedge CLK_LD);
    #1;
    check_reset_outputs();
    @(negedge CLK_LD);
    RESET    = 1'b0;
    RX_VALID = 1'b0;
    c = img_sum();
    run_load(c, 1'b0, -1);
    verify_load(c, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
